// File: rtl/piece_pixel_fetch_if.sv
// +-----------------------------------------------------------------------------
// | piece_pixel_fetch_if : raster-in, board RAM, sprite ROM and palette-out bus
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface piece_pixel_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              pix_valid;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [2:0]        sq_row;
    logic [2:0]        sq_col;
    logic [3:0]        piece_code;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_sel;
    logic [3:0]        rom_data;
    logic              out_valid;
    logic [9:0]        out_x;
    logic [9:0]        out_y;
    logic [3:0]        pal_index;
    logic              transparent;
    logic              on_board;
    logic              light_square;

    modport master (
        input  pix_valid, draw_x, draw_y, piece_code, rom_data,
        output sq_row, sq_col, rom_addr, rom_sel, out_valid, out_x, out_y,
               pal_index, transparent, on_board, light_square
    );

    modport slave (
        output pix_valid, draw_x, draw_y, piece_code, rom_data,
        input  sq_row, sq_col, rom_addr, rom_sel, out_valid, out_x, out_y,
               pal_index, transparent, on_board, light_square
    );
endinterface

`default_nettype wire

// File: rtl/piece_pixel_fetch.sv
// +-----------------------------------------------------------------------------
// | piece_pixel_fetch : 3-stage pixel -> square/offset -> sprite ROM fetch
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module piece_pixel_fetch #(
    parameter int SQ_SIZE    = 56,
    parameter int BOARD_X0   = 96,
    parameter int BOARD_Y0   = 16,
    parameter int ADDR_W     = 12,
    parameter int TRANSP_IDX = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    piece_pixel_fetch_if.master bus
);
    localparam int              OFF_W      = $clog2(SQ_SIZE);
    localparam logic [9:0]      c_x0       = 10'(BOARD_X0);
    localparam logic [9:0]      c_x1       = 10'(BOARD_X0 + 8 * SQ_SIZE);
    localparam logic [9:0]      c_y0       = 10'(BOARD_Y0);
    localparam logic [9:0]      c_y1       = 10'(BOARD_Y0 + 8 * SQ_SIZE);
    localparam logic [OFF_W-1:0] c_off_last = OFF_W'(SQ_SIZE - 1);
    localparam logic [ADDR_W-1:0] c_sq     = ADDR_W'(SQ_SIZE);
    localparam logic [3:0]      c_transp   = 4'(TRANSP_IDX);

    logic [2:0]        col_q, col_d, row_q, row_d;
    logic [OFF_W-1:0]  x_off_q, x_off_d, y_off_q, y_off_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              synced_q, synced_d;
    logic              s1_valid_q, s1_valid_d, s1_onb_q, s1_onb_d;
    logic [9:0]        s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic              s2_valid_q, s2_valid_d, s2_onb_q, s2_onb_d;
    logic              s2_empty_q, s2_empty_d, s2_light_q, s2_light_d;
    logic [9:0]        s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        rom_sel_q, rom_sel_d;
    logic              out_valid_q, out_valid_d, on_board_q, on_board_d;
    logic              out_empty_q, out_empty_d, light_q, light_d;
    logic [9:0]        out_x_q, out_x_d, out_y_q, out_y_d;

    logic w_in_board, w_first_col, w_first_row;

    assign w_in_board  = (bus.draw_x >= c_x0) && (bus.draw_x < c_x1) &&
                         (bus.draw_y >= c_y0) && (bus.draw_y < c_y1);
    assign w_first_col = (bus.draw_x == c_x0);
    assign w_first_row = (bus.draw_y == c_y0);

    always_comb begin
        col_d       = col_q;
        x_off_d     = x_off_q;
        row_d       = row_q;
        y_off_d     = y_off_q;
        line_base_d = line_base_q;
        synced_d    = synced_q;
        // Counters double as the stage-1 registers: they hold the square and
        // offset of the pixel that was just accepted.
        if (bus.pix_valid && w_in_board) begin
            if (w_first_col) begin
                col_d   = 3'd0;
                x_off_d = '0;
                if (w_first_row) begin
                    row_d       = 3'd0;
                    y_off_d     = '0;
                    line_base_d = '0;
                    synced_d    = 1'b1;
                end else if (y_off_q == c_off_last) begin
                    row_d       = row_q + 3'd1;
                    y_off_d     = '0;
                    line_base_d = '0;
                end else begin
                    y_off_d     = y_off_q + OFF_W'(1);
                    line_base_d = line_base_q + c_sq;
                end
            end else if (x_off_q == c_off_last) begin
                col_d   = col_q + 3'd1;
                x_off_d = '0;
            end else begin
                x_off_d = x_off_q + OFF_W'(1);
            end
        end

        s1_valid_d  = bus.pix_valid;
        s1_onb_d    = bus.pix_valid && w_in_board && synced_d;
        s1_x_d      = bus.draw_x;
        s1_y_d      = bus.draw_y;

        s2_valid_d  = s1_valid_q;
        s2_onb_d    = s1_onb_q;
        s2_empty_d  = (bus.piece_code == 4'd0);
        s2_light_d  = ~(row_q[0] ^ col_q[0]);
        s2_x_d      = s1_x_q;
        s2_y_d      = s1_y_q;
        rom_addr_d  = line_base_q + ADDR_W'(x_off_q);
        rom_sel_d   = s2_empty_d ? 4'd0 : bus.piece_code - 4'd1;

        out_valid_d = s2_valid_q;
        on_board_d  = s2_onb_q;
        out_empty_d = s2_empty_q;
        light_d     = s2_light_q;
        out_x_d     = s2_x_q;
        out_y_d     = s2_y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0; x_off_q <= '0; row_q <= '0; y_off_q <= '0;
            line_base_q <= '0; synced_q <= 1'b0;
            s1_valid_q <= 1'b0; s1_onb_q <= 1'b0; s1_x_q <= '0; s1_y_q <= '0;
            s2_valid_q <= 1'b0; s2_onb_q <= 1'b0; s2_empty_q <= 1'b0;
            s2_light_q <= 1'b0; s2_x_q <= '0; s2_y_q <= '0;
            rom_addr_q <= '0; rom_sel_q <= '0;
            out_valid_q <= 1'b0; on_board_q <= 1'b0; out_empty_q <= 1'b0;
            light_q <= 1'b0; out_x_q <= '0; out_y_q <= '0;
        end else begin
            col_q <= col_d; x_off_q <= x_off_d; row_q <= row_d; y_off_q <= y_off_d;
            line_base_q <= line_base_d; synced_q <= synced_d;
            s1_valid_q <= s1_valid_d; s1_onb_q <= s1_onb_d;
            s1_x_q <= s1_x_d; s1_y_q <= s1_y_d;
            s2_valid_q <= s2_valid_d; s2_onb_q <= s2_onb_d; s2_empty_q <= s2_empty_d;
            s2_light_q <= s2_light_d; s2_x_q <= s2_x_d; s2_y_q <= s2_y_d;
            rom_addr_q <= rom_addr_d; rom_sel_q <= rom_sel_d;
            out_valid_q <= out_valid_d; on_board_q <= on_board_d;
            out_empty_q <= out_empty_d; light_q <= light_d;
            out_x_q <= out_x_d; out_y_q <= out_y_d;
        end
    end

    // Stage 3 is completed combinationally from the synchronous ROM output so
    // that the result lands exactly three cycles after the input pixel.
    assign bus.pal_index    = (out_valid_q && on_board_q && !out_empty_q) ? bus.rom_data : 4'd0;
    assign bus.transparent  = out_valid_q &&
                              (!on_board_q || out_empty_q || (bus.rom_data == c_transp));
    assign bus.sq_row       = row_q;
    assign bus.sq_col       = col_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_sel      = rom_sel_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.on_board     = on_board_q;
    assign bus.light_square = light_q;
    assign bus.out_x        = out_x_q;
    assign bus.out_y        = out_y_q;
endmodule

`default_nettype wire

// File: tb/tb_piece_pixel_fetch.sv
// +-----------------------------------------------------------------------------
// | tb_piece_pixel_fetch : directed self-checking bench for piece_pixel_fetch
// | Revision 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_piece_pixel_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piece_pixel_fetch_if #(.ADDR_W(12)) bus ();

    piece_pixel_fetch #(
        .SQ_SIZE(56), .BOARD_X0(96), .BOARD_Y0(16), .ADDR_W(12), .TRANSP_IDX(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] board [8][8];
    logic [3:0] rom_const;
    assign bus.piece_code = board[bus.sq_row][bus.sq_col];
    always @(posedge clk) bus.rom_data <= rom_const;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cap_addr [1024], cap_sel [1024], cap_row [1024], cap_col [1024];
    int cap_pal [1024], cap_tr [1024], cap_onb [1024], cap_light [1024], cap_cyc [1024];
    int n_pulse = 0, n_onb = 0, n_opaque = 0;
    int addr_p1, sel_p1, row_p1, row_p2, col_p1, col_p2;

    // Realign stage-1/stage-2 outputs with the stage-3 slot of the same pixel.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            cap_addr[bus.out_x]  = addr_p1;
            cap_sel[bus.out_x]   = sel_p1;
            cap_row[bus.out_x]   = row_p2;
            cap_col[bus.out_x]   = col_p2;
            cap_pal[bus.out_x]   = int'(bus.pal_index);
            cap_tr[bus.out_x]    = int'(bus.transparent);
            cap_onb[bus.out_x]   = int'(bus.on_board);
            cap_light[bus.out_x] = int'(bus.light_square);
            cap_cyc[bus.out_x]   = cyc;
            n_pulse++;
            if (bus.on_board) n_onb++;
            if (!bus.transparent) n_opaque++;
        end
        row_p2 = row_p1; col_p2 = col_p1;
        row_p1 = int'(bus.sq_row); col_p1 = int'(bus.sq_col);
        addr_p1 = int'(bus.rom_addr); sel_p1 = int'(bus.rom_sel);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int y);
        @(posedge clk); #1;
        bus.pix_valid = 1'b1;
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.pix_valid = 1'b0;
        end
    endtask

    task automatic clear_counts();
        n_pulse = 0; n_onb = 0; n_opaque = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                board[r][c] = 4'd5;
        rom_const = 4'd7;
        bus.pix_valid = 1'b1;
        bus.draw_x = 10'd96;
        bus.draw_y = 10'd16;
        idle(3);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_on_board", 32'(bus.on_board), 0);
        check("rst_transparent", 32'(bus.transparent), 0);
        check("rst_pal", 32'(bus.pal_index), 0);
        check("rst_rom_addr", 32'(bus.rom_addr), 0);
        check("rst_sq_row", 32'(bus.sq_row), 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single pixel, cycle-exact latency
        send(96, 16);
        idle(1);
        check("t1_sq_row", 32'(bus.sq_row), 0);
        check("t1_sq_col", 32'(bus.sq_col), 0);
        check("t1_valid_c1", 32'(bus.out_valid), 0);
        idle(1);
        check("t1_rom_addr", 32'(bus.rom_addr), 0);
        check("t1_rom_sel", 32'(bus.rom_sel), 4);
        check("t1_valid_c2", 32'(bus.out_valid), 0);
        idle(1);
        check("t1_valid_c3", 32'(bus.out_valid), 1);
        check("t1_on_board", 32'(bus.on_board), 1);
        check("t1_pal", 32'(bus.pal_index), 7);
        check("t1_transp", 32'(bus.transparent), 0);
        check("t1_light", 32'(bus.light_square), 1);
        check("t1_out_x", 32'(bus.out_x), 96);
        idle(1);
        check("t1_valid_c4", 32'(bus.out_valid), 0);

        // Full line with board edges
        idle(4); clear_counts();
        for (int x = 94; x <= 545; x++) send(x, 16);
        idle(6);
        check("t2_pulses", 32'(n_pulse), 452);
        check("t2_addr151", 32'(cap_addr[151]), 55);
        check("t2_col151", 32'(cap_col[151]), 0);
        check("t2_addr152", 32'(cap_addr[152]), 0);
        check("t2_col152", 32'(cap_col[152]), 1);
        check("t2_addr543", 32'(cap_addr[543]), 55);
        check("t2_col543", 32'(cap_col[543]), 7);
        check("t2_onb94", 32'(cap_onb[94]), 0);
        check("t2_onb95", 32'(cap_onb[95]), 0);
        check("t2_onb96", 32'(cap_onb[96]), 1);
        check("t2_onb543", 32'(cap_onb[543]), 1);
        check("t2_onb544", 32'(cap_onb[544]), 0);
        check("t2_onb545", 32'(cap_onb[545]), 0);
        check("t2_tr545", 32'(cap_tr[545]), 1);
        check("t2_pal545", 32'(cap_pal[545]), 0);

        // Row progression
        for (int x = 96; x <= 100; x++) send(x, 17);
        idle(6);
        check("t3_addr100", 32'(cap_addr[100]), 60);
        for (int y = 18; y <= 72; y++) send(96, y);
        idle(6);
        check("t3_row72", 32'(cap_row[96]), 1);
        check("t3_addr72", 32'(cap_addr[96]), 0);
        check("t3_light72", 32'(cap_light[96]), 0);

        // Empty square, then transparent-key pixel
        board[1][0] = 4'd0;
        send(96, 72);
        idle(6);
        check("t4_empty_tr", 32'(cap_tr[96]), 1);
        check("t4_empty_pal", 32'(cap_pal[96]), 0);
        check("t4_empty_sel", 32'(cap_sel[96]), 0);
        board[1][0] = 4'd3;
        rom_const = 4'd1;
        send(96, 73);
        idle(6);
        check("t4_key_tr", 32'(cap_tr[96]), 1);
        check("t4_key_pal", 32'(cap_pal[96]), 1);
        check("t4_key_sel", 32'(cap_sel[96]), 2);
        rom_const = 4'd7;

        // Input gap mid-line
        clear_counts();
        for (int x = 96; x <= 200; x++) send(x, 16);
        idle(3);
        for (int x = 201; x <= 210; x++) send(x, 16);
        idle(6);
        check("t5_pulses", 32'(n_pulse), 115);
        check("t5_gap_slots", 32'(cap_cyc[201] - cap_cyc[200]), 4);
        check("t5_addr201", 32'(cap_addr[201]), 49);
        check("t5_col201", 32'(cap_col[201]), 1);
        check("t5_tr201", 32'(cap_tr[201]), 0);

        // Reset mid-frame: everything unsynced until the next frame start
        for (int x = 96; x <= 100; x++) send(x, 200);
        @(posedge clk); #1; rst_n = 1'b0; bus.pix_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; clear_counts();
        sent = 0;
        for (int y = 201; y <= 203; y++)
            for (int x = 94; x <= 545; x++) begin
                send(x, y);
                sent++;
            end
        for (int x = 96; x <= 100; x++) begin
            send(x, 471);
            sent++;
        end
        idle(6);
        check("t6_pulses", 32'(n_pulse), 32'(sent));
        check("t6_onb_count", 32'(n_onb), 0);
        check("t6_opaque_count", 32'(n_opaque), 0);
        send(96, 16);
        idle(6);
        check("t6_resync_onb", 32'(cap_onb[96]), 1);
        check("t6_resync_pal", 32'(cap_pal[96]), 7);
        check("t6_resync_tr", 32'(cap_tr[96]), 0);
        check("t6_resync_addr", 32'(cap_addr[96]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
